// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding source and EX/MEM outputs of the execute stage.
// The slave modport is the execute stage; the master modport is its environment.
interface ex_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]            wb_ctrl_i;
    logic [1:0]            mem_ctrl_i;
    logic [4:0]            ex_ctrl_i;
    logic [DATA_WIDTH-1:0] data1_i;
    logic [DATA_WIDTH-1:0] data2_i;
    logic [DATA_WIDTH-1:0] extended_i;
    logic [4:0]            rs1_i;
    logic [4:0]            rs2_i;
    logic [4:0]            rd_i;
    logic [2:0]            funct3_i;
    logic [DATA_WIDTH-1:0] branch_addr_i;
    logic                  branch_i;
    logic [4:0]            memwb_rd_i;
    logic                  memwb_regwrite_i;
    logic [DATA_WIDTH-1:0] memwb_result_i;

    logic [1:0]            wb_ctrl_o;
    logic [1:0]            mem_ctrl_o;
    logic [4:0]            rd_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic [DATA_WIDTH-1:0] store_data_o;
    logic                  branch_taken_o;
    logic [DATA_WIDTH-1:0] branch_target_o;
    logic                  stall_o;

    modport master (
        output wb_ctrl_i, mem_ctrl_i, ex_ctrl_i, data1_i, data2_i, extended_i,
               rs1_i, rs2_i, rd_i, funct3_i, branch_addr_i, branch_i,
               memwb_rd_i, memwb_regwrite_i, memwb_result_i,
        input  wb_ctrl_o, mem_ctrl_o, rd_o, result_o, store_data_o,
               branch_taken_o, branch_target_o, stall_o
    );

    modport slave (
        input  wb_ctrl_i, mem_ctrl_i, ex_ctrl_i, data1_i, data2_i, extended_i,
               rs1_i, rs2_i, rd_i, funct3_i, branch_addr_i, branch_i,
               memwb_rd_i, memwb_regwrite_i, memwb_result_i,
        output wb_ctrl_o, mem_ctrl_o, rd_o, result_o, store_data_o,
               branch_taken_o, branch_target_o, stall_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and a stalling shift-add
// multiplier. All state, including the EX/MEM register, updates on the falling edge.
module ex_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input logic       clk_i,
    input logic       rst_ni,
    ex_stage_if.slave bus
);
    localparam int unsigned CntW = $clog2(MUL_CYCLES);
    localparam logic [3:0] OpMul = 4'd10;

    typedef enum logic {StIdle, StMul} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, sd_lat_q, sd_lat_d;
    logic [1:0]            wb_lat_q, wb_lat_d, mem_lat_q, mem_lat_d;
    logic [4:0]            rd_lat_q, rd_lat_d;

    logic [1:0]            wb_q, wb_d, mem_q, mem_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] res_q, res_d, sd_q, sd_d, tgt_q, tgt_d;
    logic                  bt_q, bt_d;

    logic [DATA_WIDTH-1:0] fwd_a, fwd_b, op_b, alu_res, acc_next;
    logic [3:0]            alu_op;
    logic [4:0]            shamt;
    logic                  is_mul, mul_last, cond, stall;

    assign alu_op   = bus.ex_ctrl_i[3:0];
    assign is_mul   = (alu_op == OpMul);
    assign mul_last = (cnt_q == CntW'(MUL_CYCLES - 1));

    // EX/MEM forwarding is suppressed for loads: result_o is only an address then.
    always_comb begin
        fwd_a = bus.data1_i;
        if (bus.rs1_i == 5'd0) begin
            fwd_a = bus.data1_i;
        end else if (wb_q[1] && !wb_q[0] && rd_q == bus.rs1_i) begin
            fwd_a = res_q;
        end else if (bus.memwb_regwrite_i && bus.memwb_rd_i == bus.rs1_i) begin
            fwd_a = bus.memwb_result_i;
        end
    end

    always_comb begin
        fwd_b = bus.data2_i;
        if (bus.rs2_i == 5'd0) begin
            fwd_b = bus.data2_i;
        end else if (wb_q[1] && !wb_q[0] && rd_q == bus.rs2_i) begin
            fwd_b = res_q;
        end else if (bus.memwb_regwrite_i && bus.memwb_rd_i == bus.rs2_i) begin
            fwd_b = bus.memwb_result_i;
        end
    end

    assign op_b  = bus.ex_ctrl_i[4] ? bus.extended_i : fwd_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = fwd_a + op_b;
            4'd1:    alu_res = fwd_a - op_b;
            4'd2:    alu_res = fwd_a & op_b;
            4'd3:    alu_res = fwd_a | op_b;
            4'd4:    alu_res = fwd_a ^ op_b;
            4'd5:    alu_res = fwd_a << shamt;
            4'd6:    alu_res = fwd_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(fwd_a) >>> shamt);
            4'd8:    alu_res = DATA_WIDTH'($signed(fwd_a) < $signed(op_b));
            4'd9:    alu_res = DATA_WIDTH'(fwd_a < op_b);
            4'd11:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Branches always compare the two register operands, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (bus.funct3_i)
            3'b000:  cond = (fwd_a == fwd_b);
            3'b001:  cond = (fwd_a != fwd_b);
            3'b100:  cond = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  cond = (fwd_a < fwd_b);
            3'b111:  cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign acc_next = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);

    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (is_mul) state_d = StMul;
            StMul:   if (mul_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        sd_lat_d  = sd_lat_q;
        wb_lat_d  = wb_lat_q;
        mem_lat_d = mem_lat_q;
        rd_lat_d  = rd_lat_q;
        wb_d      = wb_q;
        mem_d     = mem_q;
        rd_d      = rd_q;
        res_d     = res_q;
        sd_d      = sd_q;
        bt_d      = bt_q;
        tgt_d     = tgt_q;
        unique case (state_q)
            StIdle: begin
                if (is_mul) begin
                    stall     = 1'b1;
                    a_d       = fwd_a;
                    b_d       = op_b;
                    sd_lat_d  = fwd_b;
                    wb_lat_d  = bus.wb_ctrl_i;
                    mem_lat_d = bus.mem_ctrl_i;
                    rd_lat_d  = bus.rd_i;
                    acc_d     = '0;
                    cnt_d     = '0;
                    wb_d      = '0;
                    mem_d     = '0;
                    bt_d      = 1'b0;
                end else begin
                    wb_d  = bus.wb_ctrl_i;
                    mem_d = bus.mem_ctrl_i;
                    rd_d  = bus.rd_i;
                    res_d = alu_res;
                    sd_d  = fwd_b;
                    bt_d  = bus.branch_i && cond;
                    tgt_d = bus.branch_addr_i;
                end
            end
            StMul: begin
                stall = !mul_last;
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                wb_d  = '0;
                mem_d = '0;
                bt_d  = 1'b0;
                if (mul_last) begin
                    res_d = acc_next;
                    wb_d  = wb_lat_q;
                    mem_d = mem_lat_q;
                    rd_d  = rd_lat_q;
                    sd_d  = sd_lat_q;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sd_lat_q  <= '0;
            wb_lat_q  <= '0;
            mem_lat_q <= '0;
            rd_lat_q  <= '0;
            wb_q      <= '0;
            mem_q     <= '0;
            rd_q      <= '0;
            res_q     <= '0;
            sd_q      <= '0;
            bt_q      <= 1'b0;
            tgt_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sd_lat_q  <= sd_lat_d;
            wb_lat_q  <= wb_lat_d;
            mem_lat_q <= mem_lat_d;
            rd_lat_q  <= rd_lat_d;
            wb_q      <= wb_d;
            mem_q     <= mem_d;
            rd_q      <= rd_d;
            res_q     <= res_d;
            sd_q      <= sd_d;
            bt_q      <= bt_d;
            tgt_q     <= tgt_d;
        end
    end

    assign bus.wb_ctrl_o       = wb_q;
    assign bus.mem_ctrl_o      = mem_q;
    assign bus.rd_o            = rd_q;
    assign bus.result_o        = res_q;
    assign bus.store_data_o    = sd_q;
    assign bus.branch_taken_o  = bt_q;
    assign bus.branch_target_o = tgt_q;
    assign bus.stall_o         = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus random instructions against a transaction-level
// model of the EX/MEM outputs (forwarding, ALU, branch, 33-edge multiply).
module tb_ex_stage;
    logic clk;
    logic rst_n;

    ex_stage_if bus ();

    ex_stage dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic        src;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] baddr;
        logic        br;
        logic [4:0]  mwrd;
        logic        mwwe;
        logic [31:0] mwres;
    } instr_t;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Expected EX/MEM register contents.
    logic [1:0]  m_wb, m_mem;
    logic [4:0]  m_rd;
    logic [31:0] m_res, m_sd, m_tgt;
    logic        m_bt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (m_wb == 2'b10 && m_rd == rs) return m_res;
        if (bus.memwb_regwrite_i && bus.memwb_rd_i == rs) return bus.memwb_result_i;
        return rf;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int unsigned sh;
        sa = int'(a);
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 32'(sa >>> sh);
            4'd8:    return (sa < int'(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return a * b;
            4'd11:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return int'(a) < int'(b);
            3'b101:  return int'(a) >= int'(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input instr_t t);
        bus.wb_ctrl_i        = t.wb;
        bus.mem_ctrl_i       = t.mem;
        bus.ex_ctrl_i        = {t.src, t.op};
        bus.data1_i          = t.d1;
        bus.data2_i          = t.d2;
        bus.extended_i       = t.ext;
        bus.rs1_i            = t.rs1;
        bus.rs2_i            = t.rs2;
        bus.rd_i             = t.rd;
        bus.funct3_i         = t.f3;
        bus.branch_addr_i    = t.baddr;
        bus.branch_i         = t.br;
        bus.memwb_rd_i       = t.mwrd;
        bus.memwb_regwrite_i = t.mwwe;
        bus.memwb_result_i   = t.mwres;
    endtask

    task automatic model_clear();
        m_wb  = '0;
        m_mem = '0;
        m_rd  = '0;
        m_res = '0;
        m_sd  = '0;
        m_tgt = '0;
        m_bt  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_wb"},  32'(bus.wb_ctrl_o),      32'(m_wb));
        check({tag, "_mem"}, 32'(bus.mem_ctrl_o),     32'(m_mem));
        check({tag, "_rd"},  32'(bus.rd_o),           32'(m_rd));
        check({tag, "_res"}, bus.result_o,            m_res);
        check({tag, "_sd"},  bus.store_data_o,        m_sd);
        check({tag, "_bt"},  32'(bus.branch_taken_o), 32'(m_bt));
        check({tag, "_tgt"}, bus.branch_target_o,     m_tgt);
    endtask

    // Presents one instruction, acts as upstream (holds it while stalled) and checks outputs.
    task automatic run_instr(input instr_t t, input string tag);
        logic [31:0] a, b2, b;
        logic        taken;
        drive(t);
        #1;
        a     = m_fwd(t.rs1, t.d1);
        b2    = m_fwd(t.rs2, t.d2);
        b     = t.src ? t.ext : b2;
        taken = t.br && m_cond(t.f3, a, b2);
        if (t.op != 4'd10) begin
            check({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
            @(negedge clk);
            #1;
            m_wb  = t.wb;
            m_mem = t.mem;
            m_rd  = t.rd;
            m_res = m_alu(t.op, a, b);
            m_sd  = b2;
            m_bt  = taken;
            m_tgt = t.baddr;
            check_outputs(tag);
        end else begin
            check({tag, "_stall0"}, 32'(bus.stall_o), 32'd1);
            for (int k = 1; k <= 33; k++) begin
                @(negedge clk);
                #1;
                if (k == 1) begin
                    m_wb  = '0;
                    m_mem = '0;
                    m_bt  = 1'b0;
                end
                if (k == 33) begin
                    m_wb  = t.wb;
                    m_mem = t.mem;
                    m_rd  = t.rd;
                    m_res = m_alu(4'd10, a, b);
                    m_sd  = b2;
                    m_bt  = 1'b0;
                end
                check({tag, "_stall"}, 32'(bus.stall_o), (k < 32) ? 32'd1 : 32'd0);
                if (k == 32) drive('0);
                if (k < 33) begin
                    check({tag, "_mwb"}, 32'(bus.wb_ctrl_o), 32'(m_wb));
                    check({tag, "_mres"}, bus.result_o, m_res);
                end else begin
                    check_outputs(tag);
                end
            end
        end
    endtask

    instr_t t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rst_n = 1'b0;
        drive('0);
        @(negedge clk);
        #1;
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check_outputs("rst");
        rst_n = 1'b1;

        t = '0; t.op = 4'd0; t.rs1 = 5'd1; t.d1 = 32'd5; t.rs2 = 5'd2; t.d2 = 32'd7;
        t.rd = 5'd3; t.wb = 2'b10;
        run_instr(t, "add");
        check("add_const", bus.result_o, 32'd12);

        t = '0; t.op = 4'd1; t.rs1 = 5'd3; t.d1 = 32'd0; t.rs2 = 5'd1; t.d2 = 32'd5;
        t.rd = 5'd4; t.wb = 2'b10;
        run_instr(t, "sub_fwd");
        check("sub_fwd_const", bus.result_o, 32'd7);

        t = '0; t.op = 4'd0; t.rs1 = 5'd1; t.d1 = 32'd5; t.rs2 = 5'd2; t.d2 = 32'd7;
        t.rd = 5'd3; t.wb = 2'b11; t.mem = 2'b10;
        run_instr(t, "ld");
        t = '0; t.op = 4'd1; t.rs1 = 5'd3; t.d1 = 32'd0; t.rs2 = 5'd1; t.d2 = 32'd5;
        t.rd = 5'd4; t.wb = 2'b10; t.mwrd = 5'd3; t.mwwe = 1'b1; t.mwres = 32'd9;
        run_instr(t, "sub_mw");
        check("sub_mw_const", bus.result_o, 32'd4);

        t = '0; t.op = 4'd10; t.src = 1'b1; t.d1 = 32'hFFFF_FFFF; t.ext = 32'd3;
        t.rd = 5'd5; t.wb = 2'b10;
        run_instr(t, "mul");
        check("mul_const", bus.result_o, 32'hFFFF_FFFD);

        t = '0; t.rs1 = 5'd10; t.rs2 = 5'd11; t.d1 = 32'hFFFF_FFFF; t.d2 = 32'd1;
        t.br = 1'b1; t.baddr = 32'h0000_1000; t.f3 = 3'b100;
        run_instr(t, "blt");
        check("blt_const", 32'(bus.branch_taken_o), 32'd1);
        check("blt_tgt", bus.branch_target_o, 32'h0000_1000);
        t.f3 = 3'b110;
        run_instr(t, "bltu");
        check("bltu_const", 32'(bus.branch_taken_o), 32'd0);
        t.f3 = 3'b010;
        run_instr(t, "b010");
        check("b010_const", 32'(bus.branch_taken_o), 32'd0);

        t = '0; t.src = 1'b1; t.d1 = 32'h8000_0000; t.ext = 32'd4; t.op = 4'd7;
        run_instr(t, "sra");
        check("sra_const", bus.result_o, 32'hF800_0000);
        t.op = 4'd6;
        run_instr(t, "srl");
        check("srl_const", bus.result_o, 32'h0800_0000);
        t.op = 4'd5; t.d1 = 32'd1; t.ext = 32'd33;
        run_instr(t, "sll");
        check("sll_const", bus.result_o, 32'd2);

        // Reset in the middle of a multiply discards it.
        t = '0; t.op = 4'd10; t.d1 = 32'd6; t.src = 1'b1; t.ext = 32'd7; t.wb = 2'b10;
        t.rd = 5'd9;
        drive(t);
        for (int k = 0; k < 10; k++) @(negedge clk);
        #1;
        check("mid_stall_pre", 32'(bus.stall_o), 32'd1);
        rst_n = 1'b0;
        drive('0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        check("mid_rst_stall", 32'(bus.stall_o), 32'd0);
        check_outputs("mid_rst");
        t = '0; t.op = 4'd0; t.rs1 = 5'd1; t.d1 = 32'd5; t.rs2 = 5'd2; t.d2 = 32'd7;
        t.rd = 5'd3; t.wb = 2'b10;
        run_instr(t, "post_rst_add");
        check("post_rst_const", bus.result_o, 32'd12);

        for (int i = 0; i < 250; i++) begin
            t       = '0;
            t.wb    = 2'($urandom);
            t.mem   = 2'($urandom);
            t.src   = 1'($urandom);
            t.op    = ($urandom_range(0, 11) == 0) ? 4'd10 : 4'($urandom);
            if (t.op == 4'd10 && $urandom_range(0, 1) == 0) t.op = 4'd0;
            t.d1    = $urandom;
            t.d2    = ($urandom_range(0, 3) == 0) ? t.d1 : $urandom;
            t.ext   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            t.rs1   = 5'($urandom_range(0, 7));
            t.rs2   = 5'($urandom_range(0, 7));
            t.rd    = 5'($urandom_range(0, 7));
            t.f3    = 3'($urandom);
            t.baddr = $urandom;
            t.br    = 1'($urandom);
            t.mwrd  = 5'($urandom_range(0, 7));
            t.mwwe  = 1'($urandom);
            t.mwres = $urandom;
            run_instr(t, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
